uart_tx_buf: RTL
================

// Module: uart_tx_buf
// PURPOSE
//  Buffered UART transmitter: accepts bytes over a valid/ready handshake into a small FIFO
//  and serialises them on txd as 8N1 frames (start, 8 data bits LSB first, stop), idle high.
//  This is the far-end line driver for the uart block's rxd input, used by the calculator
//  host side and by system-level benches.
// PARAMETERS
//  CLKS_PER_BIT  16  clock cycles per serial bit; legal range 4..65535
//  FIFO_AW       2   FIFO address width; depth = 2**FIFO_AW entries (default 4)
// PORTS
//  clk         in   1           system clock, all logic on rising edge
//  rst         in   1           synchronous reset, active high
//  tx_data     in   8           byte to transmit
//  tx_valid    in   1           tx_data valid this cycle
//  tx_ready    out  1           FIFO can accept a byte (= not full)
//  txd         out  1           serial line, registered, idle 1
//  tx_busy     out  1           frame in progress (state != IDLE)
//  fifo_count  out  FIFO_AW+1   bytes held in FIFO, excluding the byte being sent
//  overflow    out  1           1-cycle pulse: tx_valid high while tx_ready low; byte dropped
// BEHAVIOUR
//  Reset (rst=1 at an edge): txd=1, tx_ready=1, tx_busy=0, fifo_count=0, overflow=0,
//   state=IDLE, FIFO pointers cleared, bit/clock counters cleared. Applies mid-frame too:
//   frame is aborted, txd returns high on that edge, queued bytes are discarded.
//  Push: tx_valid & tx_ready at an edge writes tx_data. tx_ready = (fifo_count != depth);
//   combinational from registered count only, no path from tx_valid.
//  Full: tx_ready=0; tx_valid=1 -> overflow=1 the next cycle, FIFO unchanged. No push while
//   full, even if a pop happens in the same cycle.
//  Push and pop at the same edge: fifo_count unchanged; both pointers advance, wrap modulo depth.
//  FSM states: IDLE, START, DATA, STOP; counter clk_cnt counts 0..CLKS_PER_BIT-1; bit_idx 0..7.
//   IDLE : txd=1. If fifo_count!=0: pop into shift reg, txd<=0, clk_cnt<=0 -> START.
//   START: txd=0 for CLKS_PER_BIT cycles; at clk_cnt=CLKS_PER_BIT-1 -> DATA, txd<=shift[0].
//   DATA : each bit held CLKS_PER_BIT cycles; at bit end, shift right, bit_idx++; after
//          bit_idx=7 completes -> STOP, txd<=1.
//   STOP : txd=1 for CLKS_PER_BIT cycles; at end: FIFO non-empty -> pop, txd<=0, START
//          (back-to-back, no idle gap); else -> IDLE.
//  Latency: byte pushed into empty FIFO while IDLE at edge N -> popped and txd falls at edge N+1.
//  Frame length exactly 10*CLKS_PER_BIT cycles; tx_busy high from edge N+1 for the whole
//   frame, low in IDLE only.
//  tx_data sampled only at push; later changes do not affect queued or active bytes.
//  Counter widths sized from $clog2(CLKS_PER_BIT); no wrap-around of clk_cnt beyond limit.
// TESTING (CLKS_PER_BIT=16, FIFO_AW=2 unless stated)
//  1 Reset: rst=1 for 2 cycles -> txd=1, tx_ready=1, tx_busy=0, fifo_count=0, overflow=0.
//  2 Single push 0x53 at edge N -> txd=0 over [N+1,N+17), then 1,1,0,0,1,0,1,0 at 16 cycles
//    each, stop 1 for 16 cycles; tx_busy low at N+161; receiving uart asserts rx_data=0x53.
//  3 Push 0x31 then 0x26 on consecutive cycles -> two frames, data bits 1,0,0,0,1,1,0,0 and
//    0,1,1,0,0,1,0,0, second start bit immediately after first stop, 320 cycles total busy.
//  4 Push 6 bytes on 6 consecutive cycles -> bytes 0..4 accepted (fifo_count reaches 4, tx_ready=0),
//    byte 5 dropped with one overflow pulse; exactly 5 frames transmitted in order.
//  5 rst=1 for 1 cycle during data bit 3 of a frame with 2 bytes queued -> txd=1 next edge,
//    fifo_count=0, tx_busy=0, nothing further sent; a new push 0x53 then transmits cleanly.
//  6 CLKS_PER_BIT=15, push 0x31 -> each bit exactly 15 cycles, frame 150 cycles.

Source files
------------

// File: rtl/uart_tx_buf.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_buf
//
// Buffered UART transmitter. Bytes arrive over a valid/ready handshake into a
// small FIFO and are serialised on txd as 8N1 frames: a start bit (0), eight
// data bits LSB first, and a stop bit (1). The line idles high. When the FIFO
// still holds bytes at the end of a stop bit, the next start bit follows
// immediately, with no idle gap.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (4..65535)
//   FIFO_AW       FIFO address width; depth = 2**FIFO_AW entries
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous reset, active high (aborts any frame)
//   tx_data     in   byte to transmit, sampled only when pushed
//   tx_valid    in   tx_data valid this cycle
//   tx_ready    out  FIFO can accept a byte (not full)
//   txd         out  registered serial line, idle 1
//   tx_busy     out  frame in progress (state != IDLE)
//   fifo_count  out  bytes queued, excluding the byte being sent
//   overflow    out  one-cycle pulse after a push attempt while full
// -----------------------------------------------------------------------------
module uart_tx_buf #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               txd,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    state_e                 state_q,    state_d;
    logic [CNT_W-1:0]       clk_cnt_q,  clk_cnt_d;
    logic [2:0]             bit_idx_q,  bit_idx_d;
    logic [7:0]             shift_q,    shift_d;
    logic                   txd_q,      txd_d;
    logic [FIFO_AW-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [FIFO_AW-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [FIFO_AW:0]       count_q,    count_d;
    logic                   overflow_q, overflow_d;

    logic [7:0]             mem_q [DEPTH];

    // -------------------------------------------------------------------------
    // Handshake and FIFO bookkeeping
    // -------------------------------------------------------------------------
    logic push;
    logic pop;
    logic fifo_empty;
    logic bit_end;

    // Ready depends on the registered count only, so a pop in the same cycle
    // never opens a slot for a push while full.
    assign tx_ready   = (count_q != CNT_FULL);
    assign push       = tx_valid & tx_ready;
    assign fifo_empty = (count_q == '0);
    assign bit_end    = (clk_cnt_q == CNT_LAST);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + FIFO_AW'(push);
        rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop);
        overflow_d = tx_valid & ~tx_ready;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: FIFO storage has no reset; pointers and count alone define which
    // entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    // -------------------------------------------------------------------------
    // Transmit FSM: next state, counters, shift register and line value
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    txd_d     = 1'b0;
                    clk_cnt_d = '0;
                    state_d   = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                    state_d   = S_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // Bit 1 of the current register is bit 0 after the shift.
                        shift_d   = {1'b0, shift_q[7:1]};
                        txd_d     = shift_q[1];
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (!fifo_empty) begin
                        // Back-to-back: next start bit directly after the stop bit.
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign txd        = txd_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule
